// File: rtl/fp_special_encoder.sv
// fp_special_encoder
//   Packs FP ALU result fields and a result class into an IEEE-754 single
//   precision word through a two-stage valid/ready pipeline. It maps the
//   zero/inf/NaN classes and exponent over/underflow to canonical bit patterns,
//   and it keeps sticky exception flags and a count of emitted words.
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   in_sign/in_kind     result sign, class (00 normal, 01 zero, 10 inf, 11 NaN)
//   in_exp              signed 10-bit biased exponent, not yet range checked
//   in_frac             fraction field without the hidden bit
//   out_valid/out_ready output handshake
//   out_data/out_flags  packed word and {invalid, overflow, underflow}
//   clr_sticky          synchronous clear of the sticky flags
//   sticky              accumulated {invalid, overflow, underflow}
//   res_count           number of words accepted downstream (wraps)
module fp_special_encoder #(
  parameter logic [22:0] QNAN_FRAC = 23'h400000,
  parameter bit          SAT_OVF   = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [1:0]       in_kind,
  input  logic [9:0]       in_exp,
  input  logic [22:0]      in_frac,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [2:0]       out_flags,
  input  logic             clr_sticky,
  output logic [2:0]       sticky,
  output logic [CNT_W-1:0] res_count
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned FLG_W  = 3;

  typedef enum logic [1:0] {
    KIND_NORM = 2'b00,
    KIND_ZERO = 2'b01,
    KIND_INF  = 2'b10,
    KIND_NAN  = 2'b11
  } kind_e;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q,  s1_sign_d;
  kind_e             s1_kind_q,  s1_kind_d;
  logic [EXP_W-1:0]  s1_exp_q,   s1_exp_d;
  logic [FRAC_W-1:0] s1_frac_q,  s1_frac_d;
  logic              s1_ovf_q,   s1_ovf_d;
  logic              s1_unf_q,   s1_unf_d;

  logic              s2_valid_q, s2_valid_d;
  logic [31:0]       s2_data_q,  s2_data_d;
  logic [FLG_W-1:0]  s2_flags_q, s2_flags_d;

  logic [FLG_W-1:0]  sticky_q,    sticky_d;
  logic [CNT_W-1:0]  res_count_q, res_count_d;

  logic              s1_adv, s2_adv, out_xfer;
  logic [31:0]       enc_word;
  logic [FLG_W-1:0]  enc_flags;

  // Pipeline advance conditions; S1 can refill in the same cycle S2 drains.
  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv & ~rst;
  assign out_xfer = s2_valid_q & out_ready;

  // Stage 1: capture fields and classify the exponent range on the signed value.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_kind_d  = s1_kind_q;
    s1_exp_d   = s1_exp_q;
    s1_frac_d  = s1_frac_q;
    s1_ovf_d   = s1_ovf_q;
    s1_unf_d   = s1_unf_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d = in_sign;
        s1_kind_d = kind_e'(in_kind);
        s1_exp_d  = in_exp[EXP_W-1:0];
        s1_frac_d = in_frac;
        s1_ovf_d  = (in_kind == KIND_NORM) && ($signed(in_exp) >= 10'sd255);
        s1_unf_d  = (in_kind == KIND_NORM) && ($signed(in_exp) <= 10'sd0);
      end
    end
  end

  // Canonical encoding of the stage-1 beat.
  always_comb begin
    enc_word  = '0;
    enc_flags = '0;
    unique case (s1_kind_q)
      KIND_ZERO: enc_word = {s1_sign_q, 31'b0};
      KIND_INF:  enc_word = {s1_sign_q, 8'hFF, 23'b0};
      KIND_NAN: begin
        enc_word  = {1'b0, 8'hFF, QNAN_FRAC};
        enc_flags = 3'b100;
      end
      default: begin
        if (s1_ovf_q) begin
          enc_word  = SAT_OVF ? {s1_sign_q, 8'hFE, 23'h7FFFFF}
                              : {s1_sign_q, 8'hFF, 23'b0};
          enc_flags = 3'b010;
        end else if (s1_unf_q) begin
          // Flush to signed zero; subnormals are never produced.
          enc_word  = {s1_sign_q, 31'b0};
          enc_flags = 3'b001;
        end else begin
          enc_word  = {s1_sign_q, s1_exp_q, s1_frac_q};
        end
      end
    endcase
  end

  // Stage 2: output register, held while stalled.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_flags_d = s2_flags_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d  = enc_word;
        s2_flags_d = enc_flags;
      end
    end
  end

  // Sticky flags and counter; a transfer's flags survive a coincident clear.
  always_comb begin
    sticky_d    = clr_sticky ? '0 : sticky_q;
    res_count_d = res_count_q;
    if (out_xfer) begin
      sticky_d    = sticky_d | s2_flags_q;
      res_count_d = res_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_kind_q   <= KIND_NORM;
      s1_exp_q    <= '0;
      s1_frac_q   <= '0;
      s1_ovf_q    <= 1'b0;
      s1_unf_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_flags_q  <= '0;
      sticky_q    <= '0;
      res_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_kind_q   <= s1_kind_d;
      s1_exp_q    <= s1_exp_d;
      s1_frac_q   <= s1_frac_d;
      s1_ovf_q    <= s1_ovf_d;
      s1_unf_q    <= s1_unf_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_flags_q  <= s2_flags_d;
      sticky_q    <= sticky_d;
      res_count_q <= res_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_flags = s2_flags_q;
  assign sticky    = sticky_q;
  assign res_count = res_count_q;

endmodule

// File: tb/tb_fp_special_encoder.sv
// tb_fp_special_encoder
//   Directed bench for fp_special_encoder. A second instance with saturating
//   overflow shares the same stimulus so both overflow encodings are checked.
module tb_fp_special_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [1:0]  in_kind = 2'b00;
  logic [9:0]  in_exp = '0;
  logic [22:0] in_frac = '0;
  logic        out_ready = 1'b0;
  logic        clr_sticky = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_flags, sticky;
  logic [15:0] res_count;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [2:0]  s_out_flags, s_sticky;
  logic [15:0] s_res_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_special_encoder #(.QNAN_FRAC(23'h400000), .SAT_OVF(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_kind(in_kind), .in_exp(in_exp), .in_frac(in_frac),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .clr_sticky(clr_sticky), .sticky(sticky),
    .res_count(res_count)
  );

  fp_special_encoder #(.QNAN_FRAC(23'h400000), .SAT_OVF(1'b1), .CNT_W(16)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_sign(in_sign), .in_kind(in_kind), .in_exp(in_exp), .in_frac(in_frac),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_flags(s_out_flags), .clr_sticky(clr_sticky), .sticky(s_sticky),
    .res_count(s_res_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic s, input logic [1:0] k, input logic [9:0] e,
                          input logic [22:0] f);
    in_sign = s;
    in_kind = k;
    in_exp  = e;
    in_frac = f;
  endtask

  // Present one beat to an empty pipeline; returns with the word at the output.
  task automatic send(input logic s, input logic [1:0] k, input logic [9:0] e,
                      input logic [22:0] f);
    set_beat(s, k, e, f);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("latency_not_early", 32'(out_valid), 32'd0);
    tick();
  endtask

  // Send, check both instances, then let the word transfer.
  task automatic enc(input string tag, input logic s, input logic [1:0] k,
                     input logic [9:0] e, input logic [22:0] f,
                     input logic [31:0] exp_w, input logic [31:0] exp_sat,
                     input logic [2:0] exp_f);
    send(s, k, e, f);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  out_data, exp_w);
    chk({tag, "_flags"}, 32'(out_flags), 32'(exp_f));
    chk({tag, "_sat"},   s_out_data, exp_sat);
    tick();
  endtask

  logic [31:0] bp_exp [4];
  int          idx, k;
  logic        acc;

  initial begin
    // Reset state.
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data, 32'h0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_sticky",    32'(sticky), 32'd0);
    chk("rst_count",     32'(res_count), 32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    tick();

    // Encodings.
    enc("norm_one",  1'b0, 2'b00, 10'd127, 23'h0,      32'h3F800000, 32'h3F800000, 3'b000);
    enc("zero_neg",  1'b1, 2'b01, 10'd5,   23'h123,    32'h80000000, 32'h80000000, 3'b000);
    enc("inf_pos",   1'b0, 2'b10, 10'd9,   23'h0,      32'h7F800000, 32'h7F800000, 3'b000);
    enc("nan_neg",   1'b1, 2'b11, 10'd3,   23'h1234,   32'h7FC00000, 32'h7FC00000, 3'b100);
    enc("ovf_255",   1'b0, 2'b00, 10'd255, 23'h55,     32'h7F800000, 32'h7F7FFFFF, 3'b010);
    enc("ovf_383n",  1'b1, 2'b00, 10'd383, 23'h1,      32'hFF800000, 32'hFF7FFFFF, 3'b010);
    enc("unf_m1n",   1'b1, 2'b00, 10'h3FF, 23'h5,      32'h80000000, 32'h80000000, 3'b001);
    enc("unf_zero",  1'b0, 2'b00, 10'd0,   23'h7FFFFF, 32'h00000000, 32'h00000000, 3'b001);
    enc("norm_254",  1'b0, 2'b00, 10'd254, 23'h7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 3'b000);
    enc("norm_1n",   1'b1, 2'b00, 10'd1,   23'h0,      32'h80800000, 32'h80800000, 3'b000);
    enc("unf_m512",  1'b0, 2'b00, 10'h200, 23'h3,      32'h00000000, 32'h00000000, 3'b001);
    enc("ovf_511",   1'b0, 2'b00, 10'd511, 23'h3,      32'h7F800000, 32'h7F7FFFFF, 3'b010);
    chk("sticky_all", 32'(sticky), 32'd7);
    chk("count_12",   32'(res_count), 32'd12);

    // Sticky clear alone, then accumulate, then clear with a coincident transfer.
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("sticky_clr", 32'(sticky), 32'd0);
    chk("count_hold", 32'(res_count), 32'd12);
    send(1'b1, 2'b11, 10'd0, 23'h0);
    tick();
    send(1'b0, 2'b00, 10'd260, 23'h0);
    tick();
    chk("sticky_110", 32'(sticky), 32'b110);
    send(1'b0, 2'b00, 10'h3F0, 23'h0);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("sticky_clr_set", 32'(sticky), 32'b001);
    chk("count_15", 32'(res_count), 32'd15);

    // Backpressure: four beats into a stalled output.
    for (int i = 0; i < 4; i++) bp_exp[i] = {i[0], 8'(10 + i), 23'(i * 32'h111)};
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      set_beat(idx[0], 2'b00, 10'(10 + idx), 23'(idx * 32'h111));
      #1;
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    chk("bp_accepts", 32'(idx), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", out_data, bp_exp[0]);
      tick();
    end
    out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      in_valid = (idx < 4);
      set_beat(idx[0], 2'b00, 10'(10 + idx), 23'(idx * 32'h111));
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk("bp_order", out_data, bp_exp[k]);
        k++;
      end
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_words", 32'(k), 32'd4);
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("count_19", 32'(res_count), 32'd19);

    // Reset with both stages full.
    out_ready = 1'b0;
    set_beat(1'b0, 2'b11, 10'd0, 23'h0);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_sticky", 32'(sticky), 32'b001);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid",  32'(out_valid), 32'd0);
    chk("mid_rst_sticky", 32'(sticky), 32'd0);
    chk("mid_rst_count",  32'(res_count), 32'd0);
    chk("mid_rst_ready",  32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("no_stale", 32'(out_valid), 32'd0);
    end

    // Counter wrap: 65535 streamed words, then one more.
    set_beat(1'b0, 2'b00, 10'd127, 23'h0);
    in_valid = 1'b1;
    repeat (65535) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("count_ffff", 32'(res_count), 32'h0000FFFF);
    send(1'b0, 2'b00, 10'd127, 23'h0);
    tick();
    chk("count_wrap", 32'(res_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
